pc_sequencer: RTL
=================

# pc_sequencer

Fetch-side controller that owns the program counter and sequences the instruction-fetch stage of the RISC pipeline. It drives the word-addressed PC into the fetch stage, chooses between sequential increment, stall hold and redirects (exception, branch, jump), and inserts fetch bubbles after a redirect. It sits between the hazard/branch logic of later stages and the fetch stage's instruction memory.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset.
- EXC_VECTOR, 32'h0000_0010: PC loaded on exception.
- REDIRECT_BUBBLES, 1: cycles (0–7) of invalid fetch after any redirect.
- HALT_OPCODE, 6'h3F: IR[31:26] value treated as halt (only with PC_SEQ_HALT_EN).

- CLOCK  in  1  single clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- STALL  in  1  hazard hold; freeze PC.
- EXCEPTION  in  1  redirect to EXC_VECTOR.
- BRANCH_TAKEN  in  1  redirect to BRANCH_TARGET.
- BRANCH_TARGET  in  32  branch destination (word address).
- JUMP  in  1  redirect to JUMP_TARGET.
- JUMP_TARGET  in  32  jump destination (word address).
- IR  in  32  instruction at current PC, valid in the same cycle.
- PC  out  32  registered fetch address.
- PC_M1  out  32  PC + 1, combinational, for link/return.
- FETCH_VALID  out  1  IR at PC is a real instruction.
- FLUSH  out  1  one-cycle registered pulse: discard younger in-flight instructions.
- HALTED  out  1  sequencer stopped.

## Operation
- States: BOOT, RUN, SQUASH, HALT (HALT only with PC_SEQ_HALT_EN).
- Next-PC priority per cycle: RESET > EXCEPTION > BRANCH_TAKEN > JUMP > halt detect > STALL > PC+1.
- BOOT: entered on reset; one cycle, FETCH_VALID=0, PC held; then RUN (or SQUASH/redirect if a redirect input is high).
- RUN: FETCH_VALID=1; STALL high -> PC held; otherwise PC <= PC+1.
- Redirect (EXCEPTION/BRANCH_TAKEN/JUMP high in any state except during RESET): PC <= target; FLUSH=1 next cycle; state <= SQUASH with counter = REDIRECT_BUBBLES; if REDIRECT_BUBBLES=0 go straight to RUN.
- SQUASH: FETCH_VALID=0, PC held at target, counter decrements every cycle regardless of STALL; at 1 -> RUN. New redirect restarts counter with new target.
- STALL never blocks a redirect; a redirect in a stalled cycle takes effect at that edge.
- Arithmetic: PC+1 modulo 2^32; 32'hFFFF_FFFF wraps to 32'h0000_0000. PC_M1 wraps identically.
- Targets used verbatim; no alignment checks (word addressing).

## Timing
- Reset values: PC=RESET_VECTOR, FETCH_VALID=0, FLUSH=0, HALTED=0, state=BOOT, counter=0.
- RESET mid-operation (any state, including SQUASH/HALT) wins at the next edge; all in-progress redirects dropped.
- Redirect asserted in cycle n -> PC=target and FLUSH=1 in cycle n+1; FETCH_VALID=0 for cycles n+1 .. n+REDIRECT_BUBBLES; FETCH_VALID=1 at n+REDIRECT_BUBBLES+1.
- FLUSH is exactly one cycle per redirect; back-to-back redirects give back-to-back FLUSH.
- PC stable from posedge for the full cycle, so a negedge-latched fetch stage sees a settled value.
- FETCH_VALID, HALTED registered; PC_M1 combinational from PC.

## Configuration
- PC_SEQ_HALT_EN defined: in RUN with FETCH_VALID=1, STALL=0, no redirect, IR[31:26]==HALT_OPCODE -> next cycle state HALT, PC held at halt instruction, FETCH_VALID=0, HALTED=1. HALT exits only via RESET or EXCEPTION (EXCEPTION clears HALTED, normal redirect path). BRANCH_TAKEN/JUMP ignored in HALT.
- Undefined: IR ignored, HALTED tied 0, HALT state unreachable.

## Structure
- Package pc_seq_pkg: state enum (BOOT, RUN, SQUASH, HALT), halt opcode field position [31:26], redirect-cause encoding (none/exc/branch/jump).
- One sub-module pc_next_sel: combinational priority mux producing next PC and redirect-cause; sequencer holds state, PC register, bubble counter, FLUSH.

## Test plan
- Reset then run, no stalls -> BOOT 1 cycle, PC 0,0,1,2,3; FETCH_VALID 0 then 1 from PC=0 second cycle.
- STALL high 3 cycles at PC=5 -> PC stays 5 three cycles, then 6; FLUSH stays 0.
- BRANCH_TAKEN and JUMP same cycle, targets 0x40/0x80, REDIRECT_BUBBLES=2 -> PC=0x40, FLUSH 1 cycle, FETCH_VALID 0 for 2 cycles, then PC 0x40 valid, 0x41.
- Exception during SQUASH with STALL high -> PC=EXC_VECTOR next cycle, counter restarts, second FLUSH pulse.
- PC=32'hFFFF_FFFF, no stall -> next PC 0, PC_M1 shows 0 while PC=FFFF_FFFF.
- PC_SEQ_HALT_EN: IR=32'hFC00_0000 at PC=9 -> HALTED=1, PC held 9; RESET mid-HALT -> PC=RESET_VECTOR, HALTED=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-side PC sequencer: FSM states, redirect causes
// and the halt-opcode field of the instruction word.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_EXC    = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_JUMP   = 2'd3
  } cause_e;

  localparam int HALT_OP_MSB = 31;
  localparam int HALT_OP_LSB = 26;

  function automatic logic [5:0] halt_field(input logic [31:0] ir);
    return ir[HALT_OP_MSB:HALT_OP_LSB];
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: exception > branch > jump > halt > stall > PC+1.
// Halt detection is compiled in only when PC_SEQ_HALT_EN is defined.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0010,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic [31:0] pc,
  input  state_e      state,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] ir,
  output logic [31:0] next_pc,
  output cause_e      cause,
  output logic        halt_hit
);

  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    cause    = CAUSE_NONE;
    halt_hit = 1'b0;
    next_pc  = pc;

    // A halted core only listens to exceptions.
    if (exception)
      cause = CAUSE_EXC;
    else if (state != ST_HALT) begin
      if (branch_taken)
        cause = CAUSE_BRANCH;
      else if (jump)
        cause = CAUSE_JUMP;
    end

`ifdef PC_SEQ_HALT_EN
    halt_hit = (state == ST_RUN) && !stall && (cause == CAUSE_NONE) &&
               (halt_field(ir) == HALT_OPCODE);
`endif

    case (cause)
      CAUSE_EXC:    next_pc = EXC_VECTOR;
      CAUSE_BRANCH: next_pc = branch_target;
      CAUSE_JUMP:   next_pc = jump_target;
      default: begin
        if (state == ST_RUN && !stall && !halt_hit)
          next_pc = pc + 32'd1;
      end
    endcase
  end

`ifndef PC_SEQ_HALT_EN
  logic unused_ir;
  assign unused_ir = ^{ir, HALT_OPCODE};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner for the fetch stage: sequencing, stalls, redirects with
// fetch bubbles, and (with PC_SEQ_HALT_EN defined) halt on HALT_OPCODE.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR       = 32'h0000_0010,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter logic [5:0]  HALT_OPCODE      = 6'h3F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_m1,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted
);

  localparam logic [2:0] BUBBLES = 3'(REDIRECT_BUBBLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] next_pc;
  cause_e      cause;
  logic        halt_hit;

  pc_next_sel #(
    .EXC_VECTOR  (EXC_VECTOR),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_next_sel (
    .pc            (pc),
    .state         (state_q),
    .stall         (stall),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .ir            (ir),
    .next_pc       (next_pc),
    .cause         (cause),
    .halt_hit      (halt_hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cause != CAUSE_NONE) begin
      // Any redirect restarts the bubble window with the new target.
      state_d = (BUBBLES == 3'd0) ? ST_RUN : ST_SQUASH;
      cnt_d   = BUBBLES;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (halt_hit)
            state_d = ST_HALT;
        end
        ST_SQUASH: begin
          cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          if (cnt_q <= 3'd1)
            state_d = ST_RUN;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      cnt_q       <= 3'd0;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc          <= next_pc;
      fetch_valid <= (state_d == ST_RUN);
      flush       <= (cause != CAUSE_NONE);
      halted      <= (state_d == ST_HALT);
    end
  end

  assign pc_m1 = pc + 32'd1;

endmodule
